// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: FSM state type, instruction field positions and address helper shared by the fetch unit.
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;
  localparam int INSTR_W    = 32;
  localparam int OP_HI      = 31;
  localparam int OP_LO      = 30;
  localparam int FUNCT5_BIT = 5;
  localparam int FUNCT0_BIT = 0;
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return a & ~INSTR_W'(3);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head is read combinationally and storage clears on reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           din_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [W-1:0]           head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: one-outstanding-request fetch FSM feeding a small instruction buffer, with branch redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [1:0]  dec_op,
  output logic        dec_funct5,
  output logic        dec_funct0
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  state_e                 state_q;
  logic [INSTR_W-1:0]     fetch_pc_q;
  logic [CW-1:0]          count;
  logic [2*INSTR_W-1:0]   head;
  logic                   push, pop;
  assign pop  = dec_valid & dec_ready;
  assign push = (state_q == S_WAIT) & imem_ack & ~branch_taken;
  fetch_fifo #(.DEPTH(BUF_DEPTH), .W(2 * INSTR_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(branch_taken),
    .din_i  ({imem_rdata, imem_addr}),
    .count_o(count),
    .head_o (head)
  );
  assign dec_valid  = count != '0;
  assign {dec_instr, dec_pc} = head;
  assign dec_op     = dec_instr[OP_HI:OP_LO];
  assign dec_funct5 = dec_instr[FUNCT5_BIT];
  assign dec_funct0 = dec_instr[FUNCT0_BIT];
  // A redirect in S_IDLE only retargets; the request to the new target is issued on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (branch_taken) fetch_pc_q <= word_align(branch_target);
          else if (count != FULL) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_q;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            imem_req   <= 1'b0;
            state_q    <= S_IDLE;
            fetch_pc_q <= branch_taken ? word_align(branch_target) : imem_addr + 32'd4;
          end else if (branch_taken) begin
            state_q    <= S_DROP;
            fetch_pc_q <= word_align(branch_target);
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state_q  <= S_IDLE;
          end
          if (branch_taken) fetch_pc_q <= word_align(branch_target);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch/redirect/reset scenarios with a scoreboard of words expected on the decoder port.
module tb_instr_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        dec_valid, dec_ready = 1'b0, dec_funct5, dec_funct0;
  logic [31:0] dec_instr, dec_pc;
  logic [1:0]  dec_op;
  int          vectors = 0, errors = 0, last_wait = 0;
  logic [63:0] exp_q[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_op(dec_op),
    .dec_funct5(dec_funct5), .dec_funct0(dec_funct0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[9:0], a[31:10]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Any handshake seen before the edge is a consumed entry and must match the scoreboard head.
  task automatic tick();
    logic [63:0] e;
    if (dec_valid === 1'b1 && dec_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL sb_unexpected: observed pc %h expected no entry", dec_pc);
      end else begin
        e = exp_q.pop_front();
        chk("dec_instr", dec_instr, e[63:32]);
        chk("dec_pc", dec_pc, e[31:0]);
        chk("dec_op", {30'd0, dec_op}, {30'd0, e[63:62]});
        chk("dec_funct5", {31'd0, dec_funct5}, {31'd0, e[37]});
        chk("dec_funct0", {31'd0, dec_funct0}, {31'd0, e[32]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    last_wait = 0;
    while (imem_req !== 1'b1 && last_wait < 20) begin
      tick();
      last_wait++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic peek();
    logic [63:0] e;
    chk("peek_valid", {31'd0, dec_valid}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("peek_pc", dec_pc, e[31:0]);
      chk("peek_instr", dec_instr, e[63:32]);
    end
  endtask

  task automatic fetch_one(input logic [31:0] a, input bit keep);
    wait_req();
    chk("req_addr", imem_addr, a);
    if (keep) chk("push_not_full", {31'd0, exp_q.size() < 2}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = memw(imem_addr);
    if (keep) exp_q.push_back({memw(imem_addr), imem_addr});
    tick();
    imem_ack = 1'b0;
    chk("req_gap_after_ack", {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h100);
    fetch_one(32'h100, 1);
    peek();
    fetch_one(32'h104, 1);
    chk("rate_stalled", last_wait, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_req", {31'd0, imem_req}, 32'd0);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    fetch_one(32'h108, 1);
    dec_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      fetch_one(32'h10C + 32'(4 * i), 1);
      if (i > 0) chk("stream_rate", last_wait, 32'd1);
    end
    wait_req();
    chk("pre_branch_addr", imem_addr, 32'h12C);
    branch_taken  = 1'b1;
    branch_target = 32'h203;
    tick();
    branch_taken = 1'b0;
    exp_q.delete();
    chk("drop_req_held", {31'd0, imem_req}, 32'd1);
    chk("drop_addr_held", imem_addr, 32'h12C);
    chk("drop_flush", {31'd0, dec_valid}, 32'd0);
    tick();
    chk("drop_addr_held2", imem_addr, 32'h12C);
    fetch_one(32'h12C, 0);
    chk("drop_no_valid", {31'd0, dec_valid}, 32'd0);
    fetch_one(32'h200, 1);
    peek();
    wait_req();
    chk("coinc_addr", imem_addr, 32'h204);
    imem_ack      = 1'b1;
    imem_rdata    = memw(32'h204);
    branch_taken  = 1'b1;
    branch_target = 32'h301;
    tick();
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    exp_q.delete();
    chk("coinc_no_valid", {31'd0, dec_valid}, 32'd0);
    chk("coinc_req_low", {31'd0, imem_req}, 32'd0);
    fetch_one(32'h300, 1);
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    exp_q.delete();
    chk("idle_branch_no_req", {31'd0, imem_req}, 32'd0);
    chk("idle_branch_flush", {31'd0, dec_valid}, 32'd0);
    fetch_one(32'hFFFF_FFFC, 1);
    fetch_one(32'h0000_0000, 1);
    wait_req();
    branch_taken  = 1'b1;
    branch_target = 32'h400;
    tick();
    branch_target = 32'h500;
    tick();
    branch_taken = 1'b0;
    exp_q.delete();
    chk("drop2_req", {31'd0, imem_req}, 32'd1);
    chk("drop2_addr", imem_addr, 32'h4);
    fetch_one(32'h4, 0);
    fetch_one(32'h500, 1);
    wait_req();
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h100);
    chk("midrst_valid", {31'd0, dec_valid}, 32'd0);
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_ignored", {31'd0, dec_valid}, 32'd0);
    chk("fresh_req", {31'd0, imem_req}, 32'd1);
    chk("fresh_addr", imem_addr, 32'h100);
    fetch_one(32'h100, 1);
    peek();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 imem_req  output  1  instruction-memory read request; held high until acknowledged.
REQ-006 imem_addr  output  32  word-aligned fetch address; stable while imem_req is high.
REQ-007 imem_ack  input  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 branch_taken  input  1  one-cycle redirect pulse from the execute stage.
REQ-010 branch_target  input  32  redirect address; bits [1:0] are ignored and treated as 0.
REQ-011 dec_valid  output  1  the buffer head is presented to the main decoder.
REQ-012 dec_ready  input  1  the decoder accepts the head this cycle.
REQ-013 dec_instr  output  32  head instruction word.
REQ-014 dec_pc  output  32  address of the head instruction.
REQ-015 dec_op  output  2  dec_instr[31:30]; feeds the decoder op input.
REQ-016 dec_funct5  output  1  dec_instr[5].
REQ-017 dec_funct0  output  1  dec_instr[0].

Function
REQ-018 The block SHALL use an FSM with three states:
- S_IDLE: no request outstanding.
- S_WAIT: request outstanding, data kept.
- S_DROP: request outstanding, data discarded.
REQ-019 From S_IDLE, the block SHALL assert imem_req with imem_addr=fetch_pc and enter S_WAIT whenever the buffer count is below BUF_DEPTH; otherwise it remains in S_IDLE.
REQ-020 In S_WAIT on imem_ack, the block SHALL push {imem_rdata, imem_addr} into the buffer, set fetch_pc=imem_addr+4, and return to S_IDLE.
- Addition wraps modulo 2^32; 32'hFFFF_FFFC is followed by 32'h0.
REQ-021 A new request SHALL NOT be asserted in the cycle of an ack, so consecutive requests are separated by at least one cycle.
REQ-022 A pop SHALL occur when dec_valid and dec_ready are both high.
- A simultaneous push and pop leaves the count unchanged.
- A push into a full buffer cannot occur by construction; the bench SHALL assert this.
REQ-023 dec_valid SHALL equal (count != 0), and the dec_* outputs SHALL be driven combinationally from the head entry.
REQ-024 On branch_taken, the block SHALL:
- flush the buffer to count=0, with dec_valid low the next cycle;
- set fetch_pc={branch_target[31:2],2'b00}.
- A pop in the same cycle counts as consumed.
REQ-025 branch_taken in S_WAIT without imem_ack SHALL move the FSM to S_DROP; imem_req and imem_addr stay unchanged until the ack.
REQ-026 In S_DROP, imem_ack SHALL discard the data, leave fetch_pc unchanged, and move the FSM to S_IDLE.
REQ-027 branch_taken coincident with imem_ack in S_WAIT SHALL discard the data and move to S_IDLE; the next request goes to the target.
REQ-028 branch_taken in S_IDLE SHALL redirect without any state change.
REQ-029 branch_taken in S_DROP SHALL overwrite fetch_pc with the newest target.
REQ-030 Fetch latency SHALL be as follows: with memory acking one cycle after request and the decoder always ready, instructions issue at one per two cycles.

Reset
REQ-031 While rst is high, the block SHALL force:
- imem_req=0 and imem_addr=RESET_PC;
- fetch_pc=RESET_PC;
- count=0, dec_valid=0 and FSM=S_IDLE.
REQ-032 dec_instr and dec_pc SHALL read 0 during reset.
REQ-033 The first imem_req SHALL assert in the first rising edge after rst deasserts.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; an ack arriving after reset is ignored because the FSM is in S_IDLE.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state typedef;
- INSTR_W=32 and the field positions OP_HI=31, OP_LO=30, FUNCT5_BIT=5 and FUNCT0_BIT=0.
REQ-036 The buffer SHALL be a sub-module fetch_fifo (synchronous FIFO with push, pop, flush, count and head outputs).
REQ-037 The FSM and PC logic SHALL reside in instr_fetch_unit.

Verification
REQ-038 Reset release with RESET_PC=0x100 and ack after 1 cycle -> imem_addr=0x100, then 0x104; dec_pc=0x100 and dec_instr equal the memory word.
REQ-039 dec_ready=0 with BUF_DEPTH=2 -> exactly two requests (0x0, 0x4), then imem_req stays low.
- One pop -> the next request is to 0x8.
REQ-040 branch_taken with target 0x203 while S_WAIT for 0x8 -> imem_addr holds 0x8 until ack and the data is dropped.
- Next request is 0x200; dec_valid stays low until that word arrives.
REQ-041 branch_taken coincident with imem_ack -> the acked word never appears on dec_*; the next request is to the target.
REQ-042 fetch_pc=0xFFFF_FFFC fetched -> the next request is 0x0000_0000.
REQ-043 rst pulsed while S_WAIT, with ack arriving one cycle after rst deasserts -> the ack is ignored.
- count=0, then a fresh request to RESET_PC.
